// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage bundle between the ID/EX side and the RV32M
// multiply/divide unit.
//   master: drives flush_i, start_i, funct3_i, op_a_i, op_b_i;
//           receives busy_o, done_o, result_o.
//   slave : the muldiv unit, mirror of master.
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush_i;
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output flush_i, start_i, funct3_i, op_a_i, op_b_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  flush_i, start_i, funct3_i, op_a_i, op_b_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// One shared 2*XLEN working register: shift-add multiply and restoring divide
// on operand magnitudes, with the result conditionally negated at the end.
// A normal operation takes one start cycle plus XLEN CALC cycles; done_o
// pulses in the following DONE cycle.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   mdu        ex_muldiv_unit_if.slave: flush_i, start_i, funct3_i, op_a_i,
//              op_b_i in; busy_o (stall request), done_o, result_o out
// Optional build macro MULDIV_FAST_SPECIAL_EN: divide-by-zero, signed
// overflow and multiply-by-zero go straight from IDLE to DONE.
module ex_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  ex_muldiv_unit_if.slave   mdu
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode for the start cycle
  logic            in_div, sgn_a, sgn_b, neg_a, neg_b, b_zero, neg_res;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    in_div  = mdu.funct3_i[2];
    sgn_a   = in_div ? ~mdu.funct3_i[0] : (mdu.funct3_i[1:0] != 2'b11);
    sgn_b   = in_div ? ~mdu.funct3_i[0] : ~mdu.funct3_i[1];
    neg_a   = sgn_a & mdu.op_a_i[XLEN-1];
    neg_b   = sgn_b & mdu.op_b_i[XLEN-1];
    mag_a   = neg_a ? ('0 - mdu.op_a_i) : mdu.op_a_i;
    mag_b   = neg_b ? ('0 - mdu.op_b_i) : mdu.op_b_i;
    b_zero  = (mdu.op_b_i == '0);
    // Remainder follows the dividend; a zero divisor leaves the all-ones
    // quotient un-negated.
    if (in_div)
      neg_res = mdu.funct3_i[1] ? neg_a : ((neg_a ^ neg_b) & ~b_zero);
    else
      neg_res = neg_a ^ neg_b;
`ifdef MULDIV_FAST_SPECIAL_EN
    if (in_div) begin
      special = b_zero | (~mdu.funct3_i[0] &
                          (mdu.op_a_i == {1'b1, {(XLEN-1){1'b0}}}) &
                          (mdu.op_b_i == '1));
      if (b_zero) special_res = mdu.funct3_i[1] ? mdu.op_a_i : '1;
      else        special_res = mdu.funct3_i[1] ? '0 : mdu.op_a_i;
    end else begin
      special     = (mdu.op_a_i == '0) | b_zero;
      special_res = '0;
    end
`else
    special     = 1'b0;
    special_res = '0;
`endif
  end

  // One iteration of the shared datapath
  logic [XLEN:0]     mul_sum, div_rem, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step, prod;
  logic [XLEN-1:0]   div_pick, calc_res;

  always_comb begin
    // Multiply: acc = {partial high, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: acc = {partial remainder, dividend shifting into quotient}
    div_rem  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_rem - {1'b0, opnd_q};
    div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step     = is_div_q ? div_next : mul_next;
    prod     = neg_q ? ('0 - step) : step;
    div_pick = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    if (is_div_q)
      calc_res = neg_q ? ('0 - div_pick) : div_pick;
    else
      calc_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (mdu.start_i && !mdu.flush_i) begin
          is_div_d = in_div;
          op_d     = mdu.funct3_i[1:0];
          neg_d    = neg_res;
          cnt_d    = '0;
          acc_d    = {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
          opnd_d   = in_div ? mag_b : mag_a;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          result_d = calc_res;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mdu.flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign mdu.busy_o   = ~mdu.flush_i & (((state_q == IDLE) & mdu.start_i) |
                                        (state_q == CALC));
  assign mdu.done_o   = ~mdu.flush_i & (state_q == DONE);
  assign mdu.result_o = result_q;
endmodule
